weyl_decoder: RTL and testbench
===============================

// Module: weyl_decoder
// PURPOSE
//  Serial receiver for Weyl-permuted thermometer bitstreams produced by the stream encoder.
//  Accepts one bit per handshake, position j = 0..BITSTREAM-1.
//  Each frame is decoded back to its quota (the popcount), presented on a valid/ready output.
//  Sits at the consumer end of a stochastic-computing datapath, e.g. result readback after SC arithmetic.
// PARAMETERS
//  BITSTREAM  64  frame length N in bits; power of two, >= 4
//  BASE       61  Weyl phase offset; must match the encoder
//  STRIDE     17  Weyl stride; odd, so gcd(STRIDE,N)=1; must match the encoder
// PORTS
//  clk        in   1                    clock, rising edge
//  rst_n      in   1                    asynchronous active-low reset
//  frame_clr  in   1                    synchronous abort: discard partial frame, return to S_COLLECT
//  in_valid   in   1                    in_bit is valid
//  in_ready   out  1                    block accepts a bit
//  in_bit     in   1                    stream bit at position j
//  out_valid  out  1                    decoded frame available
//  out_ready  in   1                    consumer takes the frame
//  quota_num  out  $clog2(N)+1          number of ones in the frame, 0..N
//  quota_err  out  1                    frame is not a legal Weyl thermometer (see CONFIGURATION)
// BEHAVIOUR
//  - Reset: state=S_COLLECT, pos=0, count=0, out_valid=0, quota_num=0, quota_err=0, in_ready=1.
//  - FSM S_COLLECT:
//    - in_ready=1; on in_valid&in_ready: count += in_bit; pos += 1.
//    - Accepting the bit at pos==N-1 latches quota_num/quota_err and moves to S_HOLD.
//    - pos wraps to 0 on that transition.
//  - FSM S_HOLD:
//    - in_ready=0; out_valid=1; outputs held stable while out_valid & !out_ready.
//    - On out_ready: out_valid=0 next cycle; return to S_COLLECT.
//  - Latency: out_valid rises the cycle after the last bit is accepted.
//    - Back-to-back frames cost one in_ready-low cycle per frame (no skid buffer).
//  - Width: count is $clog2(N)+1 bits so an all-ones frame reports N without overflow.
//  - frame_clr has priority over every other input, in both states:
//    - clears pos, count and tracking state; out_valid=0; goes to S_COLLECT.
//    - A bit presented in the same cycle is dropped.
//  - quota_num/quota_err retain their last values after out_valid falls; they are don't-care while out_valid=0.
//  - Reset asserted mid-frame discards the frame immediately (async) and returns all outputs to reset values.
// CONFIGURATION
//  Macro WEYL_DECODER_CHECK_EN.
//  - Defined: thermometer check is built in.
//    - Track inverse index i(j) = ((j-BASE)*STRIDE_INV) mod N.
//    - i starts at I0 = ((N-BASE%N)*STRIDE_INV) mod N; each accepted bit adds STRIDE_INV mod N.
//    - Keep max_one_i / any_one and min_zero_i / any_zero.
//    - quota_err = (any_one & any_zero & max_one_i > min_zero_i) | (count==N).
//  - Undefined: tracking logic absent; quota_err tied 0; quota_num unaffected.
// STRUCTURE
//  Package weyl_pkg:
//  - function weyl_idx(i) returning (BASE+i*STRIDE)%N;
//  - function stride_inv(STRIDE,N), modular inverse by iteration;
//  - localparams STRIDE_INV and I0;
//  - typedef enum logic {S_COLLECT,S_HOLD} weyl_dec_state_e.
//  Sub-module: one, weyl_inv_phase. Holds the i(j) accumulator plus max/min trackers, instantiated only under the macro.
// TESTING (N=64, BASE=61, STRIDE=17 -> STRIDE_INV=49, I0=19)
//  1. Encoder output for quota 0 (all zeros) -> quota_num=0, quota_err=0, out_valid 1 cycle after bit 63.
//  2. Quota 5: ones at positions {61,14,31,48,1} -> quota_num=5, quota_err=0.
//  3. Quota 63, then 64 ones -> 63/err 0, then 64/err 1 (CHECK_EN); with macro off, second frame gives err 0.
//  4. Single one at position 14 (i=1, i=0 missing) -> quota_num=1, quota_err=1 (CHECK_EN).
//  5. Hold out_ready=0 for 10 cycles on a quota-5 frame -> outputs stable, in_ready=0 throughout.
//     - Then frame_clr mid-next-frame at pos 30 -> following full frame decodes cleanly.
//  6. Assert rst_n low at pos 40 -> outputs at reset values same cycle; next full frame decodes correctly.

Source files
------------

// File: rtl/weyl_pkg.sv
// Shared types and Weyl-permutation helpers for the thermometer stream decoder.
// Default geometry: N=64, BASE=61, STRIDE=17.
package weyl_pkg;

    localparam int BITSTREAM_DEF = 64;
    localparam int BASE_DEF      = 61;
    localparam int STRIDE_DEF    = 17;

    typedef enum logic {S_COLLECT, S_HOLD} weyl_dec_state_e;

    // Stream position that carries thermometer index i.
    function automatic int weyl_idx(input int i);
        return (BASE_DEF + i * STRIDE_DEF) % BITSTREAM_DEF;
    endfunction

    // Modular inverse of an odd stride by exhaustive search; elaboration time only.
    function automatic int stride_inv(input int stride, input int n);
        int inv;
        inv = 1;
        for (int k = 1; k < n; k++) begin
            if (((stride * k) % n) == 1) begin
                inv = k;
                break;
            end
        end
        return inv;
    endfunction

    // Thermometer index of stream position 0.
    function automatic int i0_of(input int n, input int base, input int inv);
        return ((n - (base % n)) * inv) % n;
    endfunction

    localparam int STRIDE_INV = stride_inv(STRIDE_DEF, BITSTREAM_DEF);
    localparam int I0         = i0_of(BITSTREAM_DEF, BASE_DEF, STRIDE_INV);

endpackage

// File: rtl/weyl_inv_phase.sv
// Tracks the thermometer index of the current stream position and the highest-one /
// lowest-zero indices seen so far; flags a frame whose ones are not a prefix of indices.
import weyl_pkg::*;

module weyl_inv_phase #(
    parameter int N          = BITSTREAM_DEF,
    parameter int STRIDE_INV = weyl_pkg::STRIDE_INV,
    parameter int I0         = weyl_pkg::I0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic accept,
    input  logic bit_val,
    output logic order_err
);
    localparam int IW = $clog2(N);

    logic [IW-1:0] idx;
    logic [IW-1:0] max_one;
    logic [IW-1:0] min_zero;
    logic          any_one;
    logic          any_zero;

    logic [IW-1:0] max_one_nxt;
    logic [IW-1:0] min_zero_nxt;
    logic          any_one_nxt;
    logic          any_zero_nxt;

    // Indices are distinct within a frame, so a fresh one/zero only needs comparing to the tracker.
    // NOTE: every always_comb output gets a default first so no latch can be inferred.
    always_comb begin
        max_one_nxt  = max_one;
        min_zero_nxt = min_zero;
        any_one_nxt  = any_one;
        any_zero_nxt = any_zero;
        if (accept && bit_val) begin
            any_one_nxt = 1'b1;
            if (!any_one || idx > max_one)
                max_one_nxt = idx;
        end
        if (accept && !bit_val) begin
            any_zero_nxt = 1'b1;
            if (!any_zero || idx < min_zero)
                min_zero_nxt = idx;
        end
        order_err = any_one_nxt && any_zero_nxt && (max_one_nxt > min_zero_nxt);
    end

    // N is a power of two, so the mod-N index arithmetic is plain IW-bit wraparound.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx      <= IW'(I0);
            max_one  <= '0;
            min_zero <= '0;
            any_one  <= 1'b0;
            any_zero <= 1'b0;
        end else if (clr) begin
            idx      <= IW'(I0);
            max_one  <= '0;
            min_zero <= '0;
            any_one  <= 1'b0;
            any_zero <= 1'b0;
        end else if (accept) begin
            idx      <= idx + IW'(STRIDE_INV % N);
            max_one  <= max_one_nxt;
            min_zero <= min_zero_nxt;
            any_one  <= any_one_nxt;
            any_zero <= any_zero_nxt;
        end
    end

endmodule

// File: rtl/weyl_decoder.sv
// Serial decoder: counts the ones of each N-bit Weyl-permuted thermometer frame.
// Define WEYL_DECODER_CHECK_EN to build the thermometer-legality check behind quota_err.
import weyl_pkg::*;

module weyl_decoder #(
    parameter int BITSTREAM = BITSTREAM_DEF,
    parameter int BASE      = BASE_DEF,
    parameter int STRIDE    = STRIDE_DEF
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         frame_clr,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic                         in_bit,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [$clog2(BITSTREAM):0]   quota_num,
    output logic                         quota_err
);
    localparam int PW = $clog2(BITSTREAM);
    localparam int CW = PW + 1;

    if ((BITSTREAM < 4) || ((BITSTREAM & (BITSTREAM - 1)) != 0) ||
        ((STRIDE % 2) == 0) || (BASE < 0)) begin : g_bad_cfg
        $error("weyl_decoder: illegal BITSTREAM/BASE/STRIDE combination");
    end

    weyl_dec_state_e state;
    logic [PW-1:0]   pos;
    logic [CW-1:0]   count;
    logic [CW-1:0]   count_nxt;
    logic            accept;
    logic            last;
    logic            err_nxt;

    assign accept    = in_valid && in_ready;
    assign last      = (pos == PW'(BITSTREAM - 1));
    assign count_nxt = count + CW'(in_bit);

`ifdef WEYL_DECODER_CHECK_EN
    localparam int SINV = stride_inv(STRIDE, BITSTREAM);
    localparam int IST  = i0_of(BITSTREAM, BASE, SINV);

    logic order_err;

    weyl_inv_phase #(
        .N          (BITSTREAM),
        .STRIDE_INV (SINV),
        .I0         (IST)
    ) u_inv_phase (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (frame_clr || (accept && last)),
        .accept    (accept),
        .bit_val   (in_bit),
        .order_err (order_err)
    );

    assign err_nxt = order_err || (count_nxt == CW'(BITSTREAM));
`else
    assign err_nxt = 1'b0;
`endif

    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_COLLECT;
            pos       <= '0;
            count     <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            quota_num <= '0;
            quota_err <= 1'b0;
        end else if (frame_clr) begin
            state     <= S_COLLECT;
            pos       <= '0;
            count     <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
        end else begin
            case (state)
                S_COLLECT: begin
                    if (accept) begin
                        if (last) begin
                            quota_num <= count_nxt;
                            quota_err <= err_nxt;
                            pos       <= '0;
                            count     <= '0;
                            in_ready  <= 1'b0;
                            out_valid <= 1'b1;
                            state     <= S_HOLD;
                        end else begin
                            pos   <= pos + 1'b1;
                            count <= count_nxt;
                        end
                    end
                end
                S_HOLD: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= S_COLLECT;
                    end
                end
                default: begin
                    state     <= S_COLLECT;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_weyl_decoder.sv
// Directed bench for weyl_decoder: table of whole frames plus hold, abort and reset sequences.
// Expected quota_err values follow WEYL_DECODER_CHECK_EN when it is defined for the build.
module tb_weyl_decoder;

    localparam int N = 64;

`ifdef WEYL_DECODER_CHECK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    typedef struct {
        string       name;
        logic [63:0] frame;
        int          exp_num;
        bit          exp_err;
    } vec_t;

    logic       clk;
    logic       rst_n;
    logic       frame_clr;
    logic       in_valid;
    logic       in_ready;
    logic       in_bit;
    logic       out_valid;
    logic       out_ready;
    logic [6:0] quota_num;
    logic       quota_err;

    int n_vec;
    int n_bad;

    weyl_decoder dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .frame_clr (frame_clr),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_bit    (in_bit),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .quota_num (quota_num),
        .quota_err (quota_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Encoder model: thermometer index i is carried at stream position (61 + 17*i) mod 64.
    function automatic logic [63:0] thermo(input int q);
        logic [63:0] f;
        f = '0;
        for (int i = 0; i < q; i++)
            f[(61 + 17 * i) % 64] = 1'b1;
        return f;
    endfunction

    // Presents the first nbits of frame, one per cycle; inputs change on the falling edge.
    task automatic send_bits(input logic [63:0] frame, input int nbits);
        for (int j = 0; j < nbits; j++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_bit   = frame[j];
        end
        @(negedge clk);
        in_valid = 1'b0;
        in_bit   = 1'b0;
    endtask

    // After send_bits(...,64): result is due one cycle after the last bit.
    task automatic check_result(input string name, input int exp_num, input bit exp_err);
        check({name, " out_valid"}, int'(out_valid), 1);
        check({name, " in_ready"},  int'(in_ready),  0);
        check({name, " quota_num"}, int'(quota_num), exp_num);
        check({name, " quota_err"}, int'(quota_err), int'(exp_err));
    endtask

    task automatic release_result(input string name);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check({name, " out_valid drop"}, int'(out_valid), 0);
        check({name, " in_ready back"},  int'(in_ready),  1);
    endtask

    vec_t vecs[6];

    initial begin
        logic [63:0] f;
        n_vec = 0;
        n_bad = 0;

        vecs[0] = '{"quota0",  thermo(0),  0,  1'b0};
        vecs[1] = '{"quota5",  64'h0001_0000_8000_4000 | 64'h2000_0000_0000_0002, 5, 1'b0};
        vecs[2] = '{"quota63", thermo(63), 63, 1'b0};
        vecs[3] = '{"quota64", {64{1'b1}}, 64, CHK};
        vecs[4] = '{"lone14",  64'h0000_0000_0000_4000, 1, CHK};
        vecs[5] = '{"quota32", thermo(32), 32, 1'b0};

        rst_n     = 1'b0;
        frame_clr = 1'b0;
        in_valid  = 1'b0;
        in_bit    = 1'b0;
        out_ready = 1'b0;
        repeat (2) @(negedge clk);
        check("reset in_ready",  int'(in_ready),  1);
        check("reset out_valid", int'(out_valid), 0);
        check("reset quota_num", int'(quota_num), 0);
        check("reset quota_err", int'(quota_err), 0);
        rst_n = 1'b1;

        for (int v = 0; v < 6; v++) begin
            send_bits(vecs[v].frame, N);
            check_result(vecs[v].name, vecs[v].exp_num, vecs[v].exp_err);
            release_result(vecs[v].name);
        end

        // Stalled consumer: result and in_ready stay put while a bit is offered.
        send_bits(thermo(5), N);
        check_result("stall", 5, 1'b0);
        in_valid = 1'b1;
        in_bit   = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            check("stall out_valid", int'(out_valid), 1);
            check("stall in_ready",  int'(in_ready),  0);
            check("stall quota_num", int'(quota_num), 5);
        end
        in_valid = 1'b0;
        in_bit   = 1'b0;
        release_result("stall");

        // Abort after 30 ones; the bit offered alongside frame_clr is dropped.
        f = {64{1'b1}};
        send_bits(f, 30);
        frame_clr = 1'b1;
        in_valid  = 1'b1;
        in_bit    = 1'b1;
        @(negedge clk);
        frame_clr = 1'b0;
        in_valid  = 1'b0;
        in_bit    = 1'b0;
        check("clr out_valid", int'(out_valid), 0);
        check("clr in_ready",  int'(in_ready),  1);
        send_bits(thermo(5), N);
        check_result("after_clr", 5, 1'b0);
        release_result("after_clr");

        // Asynchronous reset mid-frame at position 40.
        send_bits(thermo(10) | 64'h0000_0000_0000_4000, 40);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst in_ready",  int'(in_ready),  1);
        check("rst out_valid", int'(out_valid), 0);
        check("rst quota_num", int'(quota_num), 0);
        check("rst quota_err", int'(quota_err), 0);
        @(negedge clk);
        rst_n = 1'b1;
        send_bits(thermo(7), N);
        check_result("after_rst", 7, 1'b0);
        release_result("after_rst");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
